fir_lowpass_decimator: RTL and testbench

Polyphase FIR low-pass decimator with a programmable coefficient RAM. It runs on the single system clock and derives the input sample rate internally as clk/D. It decimates by M, producing one filtered output every D·M clock cycles. It sits between the sample-rate front end and downstream low-rate processing; coefficients are loaded through a simple write port before filtering starts.

---
 rtl/fir_lowpass_decimator.sv | 118 +++++++++++
 tb/tb_fir_lowpass_decimator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_lowpass_decimator.sv
// Polyphase FIR low-pass decimator: one capture every D clocks, one output every D*M clocks.
// A single multiplier walks the current branch's taps during the idle cycles of each sample period.
module fir_lowpass_decimator #(
    parameter int ORD         = 255,
    parameter int M           = 8,
    parameter int D           = 100,
    parameter int COEFF_SIZE  = 16,
    parameter int SAMPLE_SIZE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [SAMPLE_SIZE-1:0] din,
    output logic signed [SAMPLE_SIZE-1:0] dout,
    input  logic                          c_we,
    input  logic signed [COEFF_SIZE-1:0]  c_in,
    input  logic [$clog2(ORD+1)-1:0]      c_addr
);

    localparam int TAPS   = ORD + 1;
    localparam int L      = TAPS / M;
    localparam int AW     = $clog2(TAPS);
    localparam int PW     = $clog2(D);
    localparam int SW     = (M > 1) ? $clog2(M) : 1;
    localparam int ACC_W  = 40;
    localparam int PROD_W = COEFF_SIZE + SAMPLE_SIZE;

    localparam logic signed [ACC_W-1:0] ACC_HALF = ACC_W'(1) << (COEFF_SIZE - 2);
    localparam logic signed [ACC_W-1:0] Y_MAX    = ACC_W'((longint'(1) << (SAMPLE_SIZE - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN    = ~Y_MAX;

    logic signed [COEFF_SIZE-1:0]  coef  [TAPS];
    logic signed [SAMPLE_SIZE-1:0] dline [TAPS];

    logic [PW-1:0]            phase;
    logic [SW-1:0]            samp_cnt;
    logic [SW-1:0]            cur_br;
    logic                     group_done;
    logic signed [ACC_W-1:0]  acc;

    logic [PW-1:0]            tap_j;
    logic                     mac_on;
    logic [AW-1:0]            x_idx;
    logic [AW-1:0]            k_idx;
    logic signed [PROD_W-1:0] c_ext;
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [SAMPLE_SIZE-1:0] y_sat;

    always_ff @(posedge clk) begin
        if (c_we)
            coef[c_addr] <= c_in;
    end

    // Branch p at step j multiplies x[s - jM] by h[(M-1-p) + jM]; across all
    // branches of a group this covers every tap exactly once.
    assign tap_j  = phase - PW'(1);
    assign mac_on = (phase != '0) && (phase <= PW'(L));
    assign x_idx  = AW'(tap_j) * AW'(M);
    assign k_idx  = x_idx + AW'(M - 1) - AW'(cur_br);
    assign c_ext  = PROD_W'(coef[k_idx]);
    assign x_ext  = PROD_W'(dline[x_idx]);
    assign prod   = c_ext * x_ext;

    assign acc_rnd = acc + ACC_HALF;
    assign acc_shr = acc_rnd >>> (COEFF_SIZE - 1);

    always_comb begin
        y_sat = SAMPLE_SIZE'(acc_shr);
        if (acc_shr > Y_MAX)
            y_sat = SAMPLE_SIZE'(Y_MAX);
        else if (acc_shr < Y_MIN)
            y_sat = SAMPLE_SIZE'(Y_MIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= '0;
            samp_cnt   <= '0;
            cur_br     <= '0;
            group_done <= 1'b0;
            acc        <= '0;
            dout       <= '0;
            for (int unsigned i = 0; i < TAPS; i++)
                dline[i] <= '0;
        end else if (en) begin
            if (c_we) begin
                phase      <= '0;
                samp_cnt   <= '0;
                cur_br     <= '0;
                group_done <= 1'b0;
                acc        <= '0;
            end else begin
                phase <= (phase == PW'(D - 1)) ? '0 : phase + PW'(1);
                if (phase == '0) begin
                    for (int unsigned i = 1; i < TAPS; i++)
                        dline[i] <= dline[i-1];
                    dline[0] <= din;
                    cur_br   <= samp_cnt;
                    samp_cnt <= (samp_cnt == SW'(M - 1)) ? '0 : samp_cnt + SW'(1);
                    if (samp_cnt == SW'(M - 1))
                        group_done <= 1'b1;
                    // The previous group finished its MACs during the last period.
                    if (samp_cnt == '0 && group_done) begin
                        dout       <= y_sat;
                        acc        <= '0;
                        group_done <= 1'b0;
                    end
                end else if (mac_on) begin
                    acc <= acc + ACC_W'(prod);
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_lowpass_decimator.sv
// Bench for fir_lowpass_decimator: direct-form convolution model over the captured
// sample history, compared against dout every cycle, plus hand-computed spot values.
module tb_fir_lowpass_decimator;

    localparam int TAPS = 256;
    localparam int M    = 8;
    localparam int D    = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] din;
    logic [15:0] dout;
    logic        c_we;
    logic [15:0] c_in;
    logic [7:0]  c_addr;

    int total = 0;
    int bad   = 0;
    bit check_on = 1'b0;
    longint cyc = 0;

    int          hm [TAPS];
    int          hist [$];
    int          mph = 0;
    int          ms  = 0;
    int          nout = 0;
    longint      ev [$];
    logic [15:0] exp_dout = '0;

    int          mode = 1;
    bit          garble = 1'b0;
    logic [15:0] cval = '0;
    logic [15:0] cur = '0;
    int          i0 = 0;
    int          hsym [TAPS];

    fir_lowpass_decimator dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .din    (din),
        .dout   (dout),
        .c_we   (c_we),
        .c_in   (c_in),
        .c_addr (c_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_y();
        longint acc = 0;
        int n = hist.size();
        logic [15:0] r;
        for (int k = 0; k < TAPS; k++)
            if (n - 1 - k >= 0)
                acc += longint'(hm[k]) * longint'(hist[n-1-k]);
        acc = (acc + 16384) >>> 15;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        r = acc[15:0];
        return r;
    endfunction

    // y[n] = sum h[k] x[n-k], emitted at the capture following each complete group of M
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                hist.delete();
                ms = 0;
                mph = 0;
                exp_dout = '0;
            end else begin
                if (c_we)
                    hm[c_addr] = int'($signed(c_in));
                if (en) begin
                    if (c_we) begin
                        ms = 0;
                        mph = 0;
                    end else begin
                        if (mph == 0) begin
                            if (ms > 0 && ms % M == 0) begin
                                exp_dout = model_y();
                                ev.push_back(cyc);
                                nout++;
                            end
                            hist.push_back(int'($signed(din)));
                            ms++;
                        end
                        mph = (mph == D - 1) ? 0 : mph + 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_on) begin
                total++;
                if (dout !== exp_dout) begin
                    bad++;
                    $display("FAIL dout_track t=%0t actual=%h required=%h", $time, dout, exp_dout);
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] gen_sample(input int s);
        logic [15:0] v;
        case (mode)
            0:       v = cval;
            2:       v = (s == i0) ? 16'hF000 : 16'h0000;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    task automatic drive_din();
        if (mph == 0) begin
            cur = gen_sample(ms);
            din = cur;
        end else if (garble) begin
            din = 16'($urandom);
        end else begin
            din = cur;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive_din();
            tick();
        end
    endtask

    task automatic load(input int kind);
        for (int k = 0; k < TAPS; k++) begin
            c_we   = 1'b1;
            c_addr = 8'(k);
            case (kind)
                0:       c_in = 16'(k + 1);
                1:       c_in = 16'(hsym[k]);
                default: c_in = 16'h7FFF;
            endcase
            tick();
        end
        c_we = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n837;
        int nodd;
        int start;
        int b;
        longint req;

        rst = 1'b1; en = 1'b1; c_we = 1'b0; c_addr = '0; c_in = '0; din = 16'($urandom);
        tick();
        check_on = 1'b1;
        repeat (2) begin
            din = 16'($urandom);
            tick();
        end
        check("reset_dout", longint'(dout), 0);

        // ramp coefficients h[k]=k+1 with a constant 0x0100 input
        rst = 1'b0;
        load(0);
        mode = 0; cval = 16'h0100; garble = 1'b0;
        run(800);
        check("first_period_zero", longint'(dout), 0);
        run(2401);
        check("ramp_group3", longint'(dout), 4);
        run(24000);
        check("ramp_steady", longint'(dout), 257);
        check("ramp_model", longint'(exp_dout), 257);

        // random symmetric taps, random samples, garbage between strobes, en gap
        for (int k = 0; k < TAPS / 2; k++) begin
            hsym[k] = int'($urandom_range(0, 4000)) - 2000;
            hsym[TAPS-1-k] = hsym[k];
        end
        load(1);
        ev.delete();
        mode = 1; garble = 1'b1;
        run(800 * 5 + 350);
        en = 1'b0;
        run(37);
        en = 1'b1;
        run(800 * 6);
        check("event_count", longint'(ev.size()), 11);
        n837 = 0; nodd = 0;
        for (int i = 1; i < ev.size(); i++) begin
            if (ev[i] - ev[i-1] == 837) n837++;
            else if (ev[i] - ev[i-1] != 800) nodd++;
        end
        check("gap_interval", longint'(n837), 1);
        check("other_intervals", longint'(nodd), 0);

        // impulse of -4096 at sample i0 with zero history
        rst = 1'b1; garble = 1'b0;
        tick(); tick();
        rst = 1'b0;
        mode = 2;
        i0 = int'($urandom_range(0, 7));
        for (int g = 0; g < 32; g++) begin
            start = nout;
            b = 0;
            while (nout == start && b < 1000) begin
                drive_din();
                tick();
                b++;
            end
            if (nout == start)
                check("impulse_wait", 0, 1);
            req = (longint'(-4096) * longint'(hsym[8*g + 7 - i0]) + 16384) >>> 15;
            check($sformatf("impulse_g%0d", g), longint'($signed(dout)), req);
        end

        // saturation at both rails
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        load(2);
        mode = 0; cval = 16'h7FFF;
        run(1605);
        check("sat_pos", longint'(dout), 32767);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        cval = 16'h8000;
        run(1605);
        check("sat_neg", longint'(dout), 32768);

        check_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
